keycode_encoder: RTL and testbench

- Converts a vector of physical key/pad switches into a single 8-bit USB-HID-style keycode stream, using the same key-to-code map as the note decoder.
- Lets on-board buttons or an external switch bank drive the synth without a USB keyboard.
- Sits in front of the keycode decoding logic; its output is muxed with the USB keycode path at top level.
- Synchronizes, debounces and edge-detects inputs, and applies last-pressed-wins rollover.

---
 rtl/keycode_encoder.sv | 123 ++++++++++++
 tb/tb_keycode_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/keycode_encoder.sv
// Turns a bank of raw key switches into one HID-style keycode with last-pressed-wins
// rollover. Inputs are synchronized, debounced on a slow sample tick, then edge-detected.
module keycode_encoder #(
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [17:0] key_in,
  output logic [7:0]  keycode,
  output logic        key_held,
  output logic        report_stb
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);

  logic [17:0]   sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [17:0]   prev_q;
  logic [17:0]   stable_q, stable_d;
  logic [17:0]   stable_old_q;
  logic [17:0]   agree, rise;
  logic          cur_valid_q, cur_valid_d;
  logic [4:0]    cur_idx_q, cur_idx_d;
  logic [7:0]    keycode_q, code_d;
  logic          key_held_q, report_stb_q;

  function automatic logic [4:0] lowest(input logic [17:0] v);
    logic [4:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 18; i++) begin
      if (v[i] && !found) begin
        r     = 5'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] code_of(input logic [4:0] idx);
    case (idx)
      5'd0:    return 8'h04;
      5'd1:    return 8'h1A;
      5'd2:    return 8'h16;
      5'd3:    return 8'h08;
      5'd4:    return 8'h07;
      5'd5:    return 8'h09;
      5'd6:    return 8'h17;
      5'd7:    return 8'h0A;
      5'd8:    return 8'h1C;
      5'd9:    return 8'h0B;
      5'd10:   return 8'h18;
      5'd11:   return 8'h0D;
      5'd12:   return 8'h0E;
      5'd13:   return 8'h0F;
      5'd14:   return 8'h06;
      5'd15:   return 8'h05;
      5'd16:   return 8'h11;
      5'd17:   return 8'h2C;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    tick     = (cnt_q == CW'(SAMPLE_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    // A bit is accepted only when the same level was seen on two consecutive ticks.
    agree    = ~(sync2_q ^ prev_q);
    stable_d = tick ? ((stable_q & ~agree) | (sync2_q & agree)) : stable_q;
  end

  always_comb begin
    rise        = stable_q & ~stable_old_q;
    cur_valid_d = cur_valid_q;
    cur_idx_d   = cur_idx_q;
    if (rise != '0) begin
      cur_idx_d   = lowest(rise);
      cur_valid_d = 1'b1;
    end else if (cur_valid_q && !stable_q[cur_idx_q]) begin
      if (stable_q != '0) begin
        cur_idx_d = lowest(stable_q);
      end else begin
        cur_valid_d = 1'b0;
      end
    end
    code_d = cur_valid_q ? code_of(cur_idx_q) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      stable_q     <= '0;
      stable_old_q <= '0;
      cur_valid_q  <= 1'b0;
      cur_idx_q    <= '0;
      keycode_q    <= '0;
      key_held_q   <= 1'b0;
      report_stb_q <= 1'b0;
    end else begin
      sync1_q      <= key_in;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      if (tick) prev_q <= sync2_q;
      stable_q     <= stable_d;
      stable_old_q <= stable_q;
      cur_valid_q  <= cur_valid_d;
      cur_idx_q    <= cur_idx_d;
      keycode_q    <= code_d;
      key_held_q   <= cur_valid_q;
      report_stb_q <= (code_d != keycode_q);
    end
  end

  assign keycode    = keycode_q;
  assign key_held   = key_held_q;
  assign report_stb = report_stb_q;

endmodule

// File: tb/tb_keycode_encoder.sv
// Randomized and directed bench for keycode_encoder against a set-level rollover model.
module tb_keycode_encoder;

  localparam int unsigned SD     = 4;
  localparam int unsigned SETTLE = 2 * SD + 8;
  localparam int unsigned MAXLAT = 2 * SD + 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [17:0] key_in;
  logic [7:0]  keycode;
  logic        key_held;
  logic        report_stb;

  keycode_encoder #(.SAMPLE_DIV(SD)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .key_in     (key_in),
    .keycode    (keycode),
    .key_held   (key_held),
    .report_stb (report_stb)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt;
  int last_exp;

  // Reference: debounced key set as a plain bit vector, current key as an index.
  logic [7:0]  ref_map [18] = '{8'h04, 8'h1A, 8'h16, 8'h08, 8'h07, 8'h09,
                                8'h17, 8'h0A, 8'h1C, 8'h0B, 8'h18, 8'h0D,
                                8'h0E, 8'h0F, 8'h06, 8'h05, 8'h11, 8'h2C};
  logic [17:0] m_keys;
  bit          m_valid;
  int          m_idx;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int first_set(input logic [17:0] v);
    for (int i = 0; i < 18; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_update(input logic [17:0] nk);
    logic [17:0] pressed;
    pressed = nk & ~m_keys;
    if (pressed != 0) begin
      m_idx   = first_set(pressed);
      m_valid = 1;
    end else if (m_valid && !nk[m_idx]) begin
      if (nk != 0) m_idx = first_set(nk);
      else m_valid = 0;
    end
    m_keys = nk;
  endtask

  function automatic int model_code();
    return m_valid ? int'(ref_map[m_idx]) : 0;
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
    if (report_stb) stb_cnt++;
  endtask

  task automatic set_keys(input logic [17:0] nk);
    key_in = nk;
    model_update(nk);
  endtask

  task automatic expect_code(input string tag, input int exp);
    int lat;
    int exp_stb;
    lat     = -1;
    exp_stb = (exp != last_exp) ? 1 : 0;
    stb_cnt = 0;
    for (int i = 1; i <= int'(SETTLE); i++) begin
      cyc();
      if (lat < 0 && int'(keycode) == exp) lat = i;
    end
    check_val({tag, "/code"}, int'(keycode), exp);
    check_val({tag, "/held"}, int'(key_held), (exp != 0) ? 1 : 0);
    check_val({tag, "/stb"}, stb_cnt, exp_stb);
    if (exp_stb != 0) check_val({tag, "/latency_ok"}, int'(lat >= 1 && lat <= int'(MAXLAT)), 1);
    last_exp = exp;
  endtask

  initial begin
    logic [17:0] nk;
    Reset    = 1'b1;
    key_in   = '0;
    m_keys   = '0;
    m_valid  = 0;
    m_idx    = 0;
    last_exp = 0;
    stb_cnt  = 0;

    repeat (3) cyc();
    check_val("reset/code", int'(keycode), 0);
    check_val("reset/held", int'(key_held), 0);
    check_val("reset/stb", int'(report_stb), 0);
    Reset   = 1'b0;
    stb_cnt = 0;
    repeat (100) cyc();
    check_val("idle/stb_count", stb_cnt, 0);
    check_val("idle/code", int'(keycode), 0);

    set_keys(18'h00001);  expect_code("a_press", 8'h04);
    set_keys(18'h00000);  expect_code("a_release", 8'h00);

    set_keys(18'h00004);  expect_code("s_press", 8'h16);
    set_keys(18'h01004);  expect_code("k_press", 8'h0E);
    set_keys(18'h00004);  expect_code("k_release", 8'h16);
    set_keys(18'h00000);  expect_code("s_release", 8'h00);

    set_keys(18'h00028);  expect_code("e_f_same", 8'h08);
    set_keys(18'h00008);  expect_code("f_release", 8'h08);
    set_keys(18'h00000);  expect_code("e_release", 8'h00);

    key_in = 18'h20000;  cyc();  key_in = '0;
    expect_code("glitch1", 8'h00);
    key_in = 18'h20000;  repeat (3) cyc();  key_in = '0;
    expect_code("glitch3", 8'h00);
    set_keys(18'h20000);  expect_code("space_hold", 8'h2C);
    set_keys(18'h00000);  expect_code("space_release", 8'h00);

    set_keys(18'h10000);  expect_code("n_press", 8'h11);
    Reset = 1'b1;
    cyc();
    check_val("midreset/code", int'(keycode), 0);
    check_val("midreset/held", int'(key_held), 0);
    check_val("midreset/stb", int'(report_stb), 0);
    Reset    = 1'b0;
    m_keys   = '0;
    m_valid  = 0;
    last_exp = 0;
    model_update(key_in);
    expect_code("n_after_reset", 8'h11);

    for (int k = 0; k < 60; k++) begin
      nk = m_keys ^ (18'h1 << $urandom_range(0, 17));
      if ($urandom_range(0, 1) == 1) nk = nk ^ (18'h1 << $urandom_range(0, 17));
      if ($urandom_range(0, 9) == 0) nk = '0;
      set_keys(nk);
      expect_code("rand", model_code());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
